// File: rtl/ling_add_seq.sv
// ling_add_seq: WIDTH-bit add/subtract sequenced through a single SLICE-bit Ling lookahead slice,
// least-significant slice first, with the inter-slice carry held in a register.
module ling_add_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int NG = SLICE / 4;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [WIDTH-1:0] r_opa, r_opb, r_sum;
  logic r_carry, r_cout, r_ovf;
  logic [SLICE-1:0] w_a, w_b, w_g, w_t, w_s;
  logic [NG-1:0] w_gg, w_gp;
  logic [NG:0] w_gc;
  logic w_last;
  assign w_a = r_opa[r_idx*SLICE +: SLICE];
  assign w_b = r_opb[r_idx*SLICE +: SLICE];
  assign w_last = r_idx == IW'(NSLICE - 1);
  // Group generate in Ling form: t3 & (g3 | t2(g2 | t1(g1 | t0 g0))); carries into groups by section lookahead.
  always_comb begin
    logic acc, prod, c, h;
    w_g = w_a & w_b;
    w_t = w_a | w_b;
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_s = '0;
    for (int j = 0; j < NG; j++) begin
      w_gp[j] = &w_t[4*j +: 4];
      w_gg[j] = w_t[4*j+3] & (w_g[4*j+3] | w_t[4*j+2] & (w_g[4*j+2] | w_t[4*j+1] & (w_g[4*j+1] | w_t[4*j] & w_g[4*j])));
    end
    w_gc[0] = r_carry;
    for (int j = 1; j <= NG; j++) begin
      acc = 1'b0;
      prod = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        acc = acc | (prod & w_gg[k]);
        prod = prod & w_gp[k];
      end
      w_gc[j] = acc | (prod & r_carry);
    end
    for (int j = 0; j < NG; j++) begin
      c = w_gc[j];
      for (int i = 0; i < 4; i++) begin
        w_s[4*j+i] = w_a[4*j+i] ^ w_b[4*j+i] ^ c;
        h = w_g[4*j+i] | c;
        c = w_t[4*j+i] & h;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && in_valid) w_next = RUN;
    else if (r_state == RUN && w_last) w_next = DONE;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_carry <= 1'b0;
      r_opa <= '0;
      r_opb <= '0;
      r_sum <= '0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_opa <= a;
        r_opb <= sub ? ~b : b;
        r_carry <= sub | cin;
        r_idx <= '0;
      end
    end else if (r_state == RUN) begin
      r_sum[r_idx*SLICE +: SLICE] <= w_s;
      r_carry <= w_gc[NG];
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_gc[NG];
        r_ovf <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) & (w_s[SLICE-1] != r_opa[WIDTH-1]);
      end
    end
  assign sum = r_sum;
  assign cout = r_cout;
  assign ovf = r_ovf;
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy = r_state == RUN || r_state == DONE;
endmodule
